// File: rtl/alu_pkg.sv
// alu_pkg: op codes and mul/div sequencer state encoding shared by the ALU slice
package alu_pkg;
  localparam logic [3:0] ALU_AND   = 4'd0;
  localparam logic [3:0] ALU_OR    = 4'd1;
  localparam logic [3:0] ALU_ADD   = 4'd2;
  localparam logic [3:0] ALU_MULT  = 4'd3;
  localparam logic [3:0] ALU_MULTU = 4'd4;
  localparam logic [3:0] ALU_DIV   = 4'd5;
  localparam logic [3:0] ALU_SUB   = 4'd6;
  localparam logic [3:0] ALU_SLT   = 4'd7;
  localparam logic [3:0] ALU_DIVU  = 4'd8;
  localparam logic [3:0] ALU_MFHI  = 4'd9;
  localparam logic [3:0] ALU_MFLO  = 4'd10;
  localparam logic [3:0] ALU_SLTU  = 4'd11;
  localparam logic [3:0] ALU_NOR   = 4'd12;
  localparam logic [3:0] ALU_SLL   = 4'd13;
  localparam logic [3:0] ALU_SRL   = 4'd14;
  localparam logic [3:0] ALU_SRA   = 4'd15;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} md_state_t;

  function automatic logic is_muldiv(input logic [3:0] op);
    return op == ALU_MULT || op == ALU_MULTU || op == ALU_DIV || op == ALU_DIVU;
  endfunction
endpackage

// File: rtl/alu_muldiv_if.sv
// alu_muldiv_if: request/result bundle between the execute stage and the ALU
interface alu_muldiv_if #(parameter int WIDTH = 32, parameter int SHAMT_W = 5);
  logic               start;
  logic [3:0]         AluControl;
  logic [WIDTH-1:0]   input1;
  logic [WIDTH-1:0]   input2;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   AluOutput;
  logic               ZeroFlag;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;

  modport master (
    output start, AluControl, input1, input2, shamt,
    input  AluOutput, ZeroFlag, busy, done, hi, lo
  );

  modport slave (
    input  start, AluControl, input1, input2, shamt,
    output AluOutput, ZeroFlag, busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative shift-add multiplier / restoring divider owning HI and LO
module muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  md_state_t            state;
  logic [SHAMT_W-1:0]   cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     mag_b;
  logic                 sa, sb, is_div;
  logic                 sgn, div_op, dz;
  logic [WIDTH-1:0]     mag_a_in, mag_b_in;
  logic [WIDTH:0]       mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0]   prod;

  // operand magnitudes at accept, plus one shift-add and one restoring-divide step
  always_comb begin
    sgn      = op == ALU_MULT || op == ALU_DIV;
    div_op   = op == ALU_DIV || op == ALU_DIVU;
    dz       = div_op && b == '0;
    mag_a_in = sgn && a[WIDTH-1] ? -a : a;
    mag_b_in = sgn && b[WIDTH-1] ? -b : b;
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
    div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff = div_sh - {1'b0, mag_b};
    prod     = sa ^ sb ? -acc : acc;
  end

  // acc holds {partial product | remainder, multiplier | dividend->quotient}; divide by zero preloads the fixed answer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc    <= '0;
      mag_b  <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      is_div <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state  <= dz ? S_FIX : div_op ? S_DIV : S_MUL;
          busy   <= 1'b1;
          cnt    <= '0;
          acc    <= dz ? {a, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, mag_a_in};
          mag_b  <= mag_b_in;
          sa     <= sgn && !dz && a[WIDTH-1];
          sb     <= sgn && !dz && b[WIDTH-1];
          is_div <= div_op;
        end
        S_MUL: begin
          acc   <= {mul_sum, acc[WIDTH-1:1]};
          cnt   <= cnt + 1'b1;
          state <= cnt == SHAMT_W'(WIDTH - 1) ? S_FIX : S_MUL;
        end
        S_DIV: begin
          acc   <= div_diff[WIDTH] ? {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                   : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
          cnt   <= cnt + 1'b1;
          state <= cnt == SHAMT_W'(WIDTH - 1) ? S_FIX : S_DIV;
        end
        S_FIX: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          done     <= 1'b1;
          {hi, lo} <= is_div ? {sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH],
                                sa ^ sb ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]} : prod;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: registered single-cycle ALU with an attached iterative mul/div unit
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic   clk,
  input  logic   rst_n,
  alu_muldiv_if.slave bus
);
  logic [WIDTH-1:0]   a, b, res, alu_out;
  logic [SHAMT_W-1:0] sh;
  logic               accept, md_op, simple_done, md_done;

  assign a  = bus.input1;
  assign b  = bus.input2;
  assign sh = bus.shamt;

  // simple-op result mux; MFHI/MFLO see HI/LO as they stand before the accepting edge
  always_comb begin
    accept = bus.start && !bus.busy;
    md_op  = is_muldiv(bus.AluControl);
    case (bus.AluControl)
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_ADD:  res = a + b;
      ALU_SUB:  res = a - b;
      ALU_SLT:  res = WIDTH'($signed(a) < $signed(b));
      ALU_SLTU: res = WIDTH'(a < b);
      ALU_NOR:  res = ~(a | b);
      ALU_SLL:  res = b << sh;
      ALU_SRL:  res = b >> sh;
      ALU_SRA:  res = WIDTH'($signed(b) >>> sh);
      ALU_MFHI: res = bus.hi;
      ALU_MFLO: res = bus.lo;
      default:  res = '0;
    endcase
  end

  // result register loads only for simple ops; mul/div leaves it untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out     <= '0;
      simple_done <= 1'b0;
    end else begin
      simple_done <= accept && !md_op;
      if (accept && !md_op) alu_out <= res;
    end
  end

  muldiv_seq #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_seq (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept && md_op),
    .op    (bus.AluControl),
    .a     (a),
    .b     (b),
    .busy  (bus.busy),
    .done  (md_done),
    .hi    (bus.hi),
    .lo    (bus.lo)
  );

  assign bus.AluOutput = alu_out;
  assign bus.ZeroFlag  = alu_out == '0;
  assign bus.done      = simple_done | md_done;
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: vector table, randomized model comparison and multi-cycle corner cases
module tb_alu_muldiv;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  alu_muldiv_if #(.WIDTH(32), .SHAMT_W(5)) bus ();
  alu_muldiv_if #(.WIDTH(8), .SHAMT_W(3)) bus8 ();

  alu_muldiv #(.WIDTH(32), .SHAMT_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  alu_muldiv #(.WIDTH(8), .SHAMT_W(3)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [4:0]  sh;
    logic [31:0] out, hi, lo;
    int          lat;
  } vec_t;

  vec_t        tv[22];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_out, m_hi, m_lo;
  int          m_lat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] sh, output int lat);
    int n;
    @(negedge clk);
    bus.start = 1'b1; bus.AluControl = op; bus.input1 = a; bus.input2 = b; bus.shamt = sh;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    lat = bus.done ? n + 1 : -1;
  endtask

  task automatic run8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] sh, output int lat);
    int n;
    @(negedge clk);
    bus8.start = 1'b1; bus8.AluControl = op; bus8.input1 = a; bus8.input2 = b; bus8.shamt = sh;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    n = 0;
    while (!bus8.done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    lat = bus8.done ? n + 1 : -1;
  endtask

  // architectural model: plain 64-bit arithmetic on the instruction semantics
  task automatic ref_step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh);
    logic signed [63:0] sp, sa64, sb64;
    logic [63:0]        up;
    m_lat = 1;
    case (op)
      ALU_AND:  m_out = a & b;
      ALU_OR:   m_out = a | b;
      ALU_ADD:  m_out = a + b;
      ALU_SUB:  m_out = a - b;
      ALU_SLT:  m_out = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: m_out = (a < b) ? 32'd1 : 32'd0;
      ALU_NOR:  m_out = ~(a | b);
      ALU_SLL:  m_out = b << sh;
      ALU_SRL:  m_out = b >> sh;
      ALU_SRA:  m_out = $signed(b) >>> sh;
      ALU_MFHI: m_out = m_hi;
      ALU_MFLO: m_out = m_lo;
      ALU_MULT: begin
        sa64 = $signed({{32{a[31]}}, a});
        sb64 = $signed({{32{b[31]}}, b});
        sp = sa64 * sb64;
        m_hi = sp[63:32]; m_lo = sp[31:0]; m_lat = 34;
      end
      ALU_MULTU: begin
        up = {32'b0, a} * {32'b0, b};
        m_hi = up[63:32]; m_lo = up[31:0]; m_lat = 34;
      end
      ALU_DIV: begin
        if (b == 32'd0) begin
          m_hi = a; m_lo = 32'hFFFF_FFFF; m_lat = 2;
        end else begin
          sa64 = $signed({{32{a[31]}}, a});
          sb64 = $signed({{32{b[31]}}, b});
          sp = sa64 / sb64; m_lo = sp[31:0];
          sp = sa64 % sb64; m_hi = sp[31:0];
          m_lat = 34;
        end
      end
      ALU_DIVU: begin
        if (b == 32'd0) begin
          m_hi = a; m_lo = 32'hFFFF_FFFF; m_lat = 2;
        end else begin
          m_lo = a / b; m_hi = a % b; m_lat = 34;
        end
      end
      default: m_out = 32'd0;
    endcase
  endtask

  initial begin
    int lat, n, extra;
    logic [31:0] ra, rb;
    logic [3:0]  rop;

    bus.start = 1'b0; bus.AluControl = '0; bus.input1 = '0; bus.input2 = '0; bus.shamt = '0;
    bus8.start = 1'b0; bus8.AluControl = '0; bus8.input1 = '0; bus8.input2 = '0; bus8.shamt = '0;

    tv[0]  = '{ALU_SUB,   32'd5,         32'd5,         5'd0,  32'h0,         32'h0,         32'h0,         1};
    tv[1]  = '{ALU_SRA,   32'd0,         32'h8000_0000, 5'd4,  32'hF800_0000, 32'h0,         32'h0,         1};
    tv[2]  = '{ALU_SLTU,  32'd1,         32'hFFFF_FFFF, 5'd0,  32'h1,         32'h0,         32'h0,         1};
    tv[3]  = '{ALU_SLT,   32'd1,         32'hFFFF_FFFF, 5'd0,  32'h0,         32'h0,         32'h0,         1};
    tv[4]  = '{ALU_MULT,  32'hFFFF_FFFD, 32'd7,         5'd0,  32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 34};
    tv[5]  = '{ALU_MFLO,  32'd0,         32'd0,         5'd0,  32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1};
    tv[6]  = '{ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,  32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h1,         34};
    tv[7]  = '{ALU_MFHI,  32'd0,         32'd0,         5'd0,  32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h1,         1};
    tv[8]  = '{ALU_DIV,   32'hFFFF_FFF9, 32'd2,         5'd0,  32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34};
    tv[9]  = '{ALU_DIV,   32'd9,         32'd0,         5'd0,  32'hFFFF_FFFE, 32'h9,         32'hFFFF_FFFF, 2};
    tv[10] = '{ALU_DIVU,  32'h10,        32'd0,         5'd0,  32'hFFFF_FFFE, 32'h10,        32'hFFFF_FFFF, 2};
    tv[11] = '{ALU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 5'd0,  32'hFFFF_FFFE, 32'h0,         32'h8000_0000, 34};
    tv[12] = '{ALU_MULT,  32'h8000_0000, 32'h8000_0000, 5'd0,  32'hFFFF_FFFE, 32'h4000_0000, 32'h0,         34};
    tv[13] = '{ALU_MFHI,  32'd0,         32'd0,         5'd0,  32'h4000_0000, 32'h4000_0000, 32'h0,         1};
    tv[14] = '{ALU_DIVU,  32'd100,       32'd7,         5'd0,  32'h4000_0000, 32'h2,         32'hE,         34};
    tv[15] = '{ALU_ADD,   32'hFFFF_FFFF, 32'd2,         5'd0,  32'h1,         32'h2,         32'hE,         1};
    tv[16] = '{ALU_NOR,   32'd0,         32'd0,         5'd0,  32'hFFFF_FFFF, 32'h2,         32'hE,         1};
    tv[17] = '{ALU_SRL,   32'd0,         32'hF000_0000, 5'd28, 32'hF,         32'h2,         32'hE,         1};
    tv[18] = '{ALU_SLL,   32'd0,         32'd3,         5'd31, 32'h8000_0000, 32'h2,         32'hE,         1};
    tv[19] = '{ALU_AND,   32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'hF000_F000, 32'h2,         32'hE,         1};
    tv[20] = '{ALU_OR,    32'h0F00_0000, 32'h0000_00F0, 5'd0,  32'h0F00_00F0, 32'h2,         32'hE,         1};
    tv[21] = '{ALU_DIV,   32'd7,         32'hFFFF_FFFE, 5'd0,  32'h0F00_00F0, 32'h1,         32'hFFFF_FFFD, 34};

    #1 rst_n = 1'b0;
    #1;
    chk("rst_out", 64'(bus.AluOutput), 64'h0);
    chk("rst_zero", 64'(bus.ZeroFlag), 64'h1);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    chk("rst_done", 64'(bus.done), 64'h0);
    chk("rst_hi", 64'(bus.hi), 64'h0);
    chk("rst_lo", 64'(bus.lo), 64'h0);
    chk("rst8_zero", 64'(bus8.ZeroFlag), 64'h1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      run(tv[i].op, tv[i].a, tv[i].b, tv[i].sh, lat);
      chk($sformatf("vec%0d_out", i), 64'(bus.AluOutput), 64'(tv[i].out));
      chk($sformatf("vec%0d_zero", i), 64'(bus.ZeroFlag), 64'(tv[i].out == 32'd0));
      chk($sformatf("vec%0d_hi", i), 64'(bus.hi), 64'(tv[i].hi));
      chk($sformatf("vec%0d_lo", i), 64'(bus.lo), 64'(tv[i].lo));
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(tv[i].lat));
    end

    m_out = 32'h0F00_00F0; m_hi = 32'h1; m_lo = 32'hFFFF_FFFD;
    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(15));
      case ($urandom_range(5))
        0: ra = 32'h8000_0000;
        1: ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(5))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = $urandom_range(15);
        default: rb = $urandom;
      endcase
      n = $urandom_range(31);
      ref_step(rop, ra, rb, 5'(n));
      run(rop, ra, rb, 5'(n), lat);
      chk($sformatf("rnd%0d_op%0d_out", i, rop), 64'(bus.AluOutput), 64'(m_out));
      chk($sformatf("rnd%0d_op%0d_hi", i, rop), 64'(bus.hi), 64'(m_hi));
      chk($sformatf("rnd%0d_op%0d_lo", i, rop), 64'(bus.lo), 64'(m_lo));
      chk($sformatf("rnd%0d_op%0d_lat", i, rop), 64'(lat), 64'(m_lat));
    end

    @(negedge clk);
    bus.start = 1'b1; bus.AluControl = ALU_MULTU; bus.input1 = 32'd3; bus.input2 = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.AluControl = ALU_MULT; bus.input1 = 32'd7; bus.input2 = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("ignored_busy", 64'(bus.busy), 64'h1);
    n = 0;
    while (!bus.done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ignored_done_seen", 64'(bus.done), 64'h1);
    chk("ignored_hi", 64'(bus.hi), 64'h0);
    chk("ignored_lo", 64'(bus.lo), 64'd15);
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) extra++;
    end
    chk("ignored_no_second_op", 64'(extra), 64'h0);

    run(ALU_DIVU, 32'd100, 32'd7, 5'd0, lat);
    chk("b2b_div_lo", 64'(bus.lo), 64'hE);
    run(ALU_MFLO, 32'd0, 32'd0, 5'd0, lat);
    chk("b2b_mflo_out", 64'(bus.AluOutput), 64'hE);
    chk("b2b_mflo_lat", 64'(lat), 64'h1);

    @(negedge clk);
    bus.start = 1'b1; bus.AluControl = ALU_MULT; bus.input1 = 32'hFFFF_FFFD; bus.input2 = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    chk("midrst_busy_before", 64'(bus.busy), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(bus.busy), 64'h0);
    chk("midrst_done", 64'(bus.done), 64'h0);
    chk("midrst_hi", 64'(bus.hi), 64'h0);
    chk("midrst_lo", 64'(bus.lo), 64'h0);
    chk("midrst_out", 64'(bus.AluOutput), 64'h0);
    chk("midrst_zero", 64'(bus.ZeroFlag), 64'h1);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("midrst_stays_idle", 64'(bus.busy), 64'h0);

    run8(ALU_MULTU, 8'd200, 8'd3, 3'd0, lat);
    chk("w8_multu_hi", 64'(bus8.hi), 64'h02);
    chk("w8_multu_lo", 64'(bus8.lo), 64'h58);
    chk("w8_multu_lat", 64'(lat), 64'd10);
    run8(ALU_DIV, 8'h80, 8'hFF, 3'd0, lat);
    chk("w8_divmin_hi", 64'(bus8.hi), 64'h00);
    chk("w8_divmin_lo", 64'(bus8.lo), 64'h80);
    run8(ALU_MULT, 8'h80, 8'h80, 3'd0, lat);
    chk("w8_multmin_hi", 64'(bus8.hi), 64'h40);
    chk("w8_multmin_lo", 64'(bus8.lo), 64'h00);
    run8(ALU_SRA, 8'h00, 8'h90, 3'd2, lat);
    chk("w8_sra_out", 64'(bus8.AluOutput), 64'hE4);
    chk("w8_sra_lat", 64'(lat), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised successor to the single-cycle MIPS ALU. It adds a start/done handshake, registered results, and the logical/arithmetic right shifts and SLTU. It also adds an iterative multiply/divide unit with architectural HI/LO registers, serving MULT, MULTU, DIV, DIVU, MFHI and MFLO. It sits in the execute stage, and the control unit stalls the pipeline while `busy` is high.

## Interface
Parameters:
- `WIDTH`, 32: operand, result and HI/LO width; must be ≥ 4.
- `SHAMT_W`, 5: shift-amount width; must equal clog2(`WIDTH`).

Ports:
- `clk`, in, 1: single clock, all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `start`, in, 1: operation request; sampled only when `busy`=0.
- `AluControl`, in, 4: operation code, sampled with `start`.
- `input1`, in, `WIDTH`: operand A (rs).
- `input2`, in, `WIDTH`: operand B (rt or immediate).
- `shamt`, in, `SHAMT_W`: shift amount.
- `AluOutput`, out, `WIDTH`: registered result of the last completed op.
- `ZeroFlag`, out, 1: high when `AluOutput` == 0.
- `busy`, out, 1: high while a mul/div is in flight.
- `done`, out, 1: one-cycle pulse when a result or HI/LO update completes.
- `hi`, out, `WIDTH`: HI register.
- `lo`, out, `WIDTH`: LO register.

## Operation
Op codes, with all unlisted codes treated as simple ops with result 0:
- 0 AND, 1 OR, 2 ADD (wraps, no overflow trap), 6 SUB, 7 SLT (signed), 11 SLTU, 12 NOR.
- 13 SLL (`input2` << `shamt`), 14 SRL, 15 SRA. These shift `input2`; this is a deliberate change from the predecessor, which shifted `input1`.
- 9 MFHI, 10 MFLO.
- 3 MULT, 4 MULTU, 5 DIV, 8 DIVU.

Simple ops:
- Computed combinationally and loaded into `AluOutput` on the edge that accepts `start`.
- `done` pulses; `busy` stays low.

Mul/div FSM states and transitions:
- IDLE → MUL or DIV on accept.
- MUL/DIV run `WIDTH` iterations, then → FIX → IDLE.
- Accept: latch the operand magnitudes (absolute values for signed ops) and the result sign bits; clear the iteration counter.
- MUL: shift-add, one multiplier bit per cycle, into a 2×`WIDTH` accumulator.
- DIV: restoring division, one quotient bit per cycle.
- FIX: apply the sign correction and load HI/LO.
  - Multiply: {HI,LO} = product.
  - Divide: LO = quotient, HI = remainder.
  - Signed divide: quotient sign = sign A xor sign B; remainder takes the sign of the dividend.
  - `AluOutput` is unchanged by mul/div.

Divide by zero (DIV or DIVU with `input2` == 0):
- Skips the iterations and goes directly to FIX.
- LO = all ones, HI = `input1`.

Boundary conditions:
- `start` while `busy`=1 is ignored: no queueing, no error.
- MULT of −2^(WIDTH−1) × −2^(WIDTH−1) yields the correct 2×`WIDTH` product.
- DIV of −2^(WIDTH−1) / −1 gives LO = −2^(WIDTH−1) (wraps) and HI = 0.
- MFHI/MFLO return the HI/LO values as of the accepting edge.

Reset: asynchronous assertion at any time, including mid-operation, forces:
- FSM to IDLE.
- `AluOutput`, `hi`, `lo` = 0.
- `busy` = 0, `done` = 0.
- `ZeroFlag` = 1.

## Timing
Edge E0 is the edge that accepts `start`.
- Simple op: result is visible after E0, and `done` is high during the cycle E0→E1.
- Mul/div: `busy` is high from after E0 through E(`WIDTH`+1).
  - Iterations occur on E1..E`WIDTH`.
  - FIX occurs on E(`WIDTH`+1), loading HI/LO; `done` pulses in the following cycle and `busy` falls.
  - Total latency is `WIDTH`+2 edges.
- Divide by zero: FIX on E1, `done` in the cycle after E1.
- A new `start` may be accepted in the same cycle that `done` is high.
- `ZeroFlag` is combinational from the registered `AluOutput`.

## Structure
- Package `alu_pkg`: op-code localparams (`ALU_AND` … `ALU_DIVU`) and FSM state encoding.
- Sub-module `muldiv_seq`:
  - Contains the FSM, counter, accumulator and HI/LO registers.
  - Ports: `clk`/`rst_n`, start, op, operands, `busy`, `done`, `hi`, `lo`.
- Top level: simple-op mux, `AluOutput` register, and the `done` OR-merge.

## Test plan
- Reset mid-MULT: assert `rst_n`=0 at iteration 10 → `busy`=0, `hi`=`lo`=0, `AluOutput`=0, `ZeroFlag`=1 immediately.
- Simple ops (`WIDTH`=32): SUB 5−5 → `AluOutput`=0, `ZeroFlag`=1, `done` 1 cycle after start. SRA 0x80000000 by 4 → 0xF8000000. SLTU 1 vs 0xFFFFFFFF → 1. SLT → 0.
- MULT −3 × 7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB; `done` exactly 34 edges after accept. MULTU 0xFFFFFFFF² → `hi`=0xFFFFFFFE, `lo`=1.
- DIV −7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIV by 0 with `input1`=9 → `lo`=0xFFFFFFFF, `hi`=9, `done` 2 edges after accept.
- `start` pulsed during `busy` → ignored, HI/LO reflect only the first op. MFLO issued back-to-back in the `done` cycle → returns the new LO.
- `WIDTH`=8, `SHAMT_W`=3: MULTU 200 × 3 → `hi`=0x02, `lo`=0x58; latency 10 edges.
